mem_requester: RTL and testbench

//   Initiator for memory_controller, in the clk_master domain. Accepts burst commands
//   (write-fill or read) on a valid/ready port and drives write_enable/write_data/

---
 rtl/mem_requester_if.sv | 37 +++
 rtl/mem_requester.sv | 173 +++++++++++++++++
 tb/tb_mem_requester.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_requester_if.sv
// Command, memory-side and response signals of mem_requester, bundled so the
// requester and its environment connect through a single port.
interface mem_requester_if;
  // Command handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_* fields must be stable while cmd_valid is high.
  // rsp_valid is a single-cycle pulse with no backpressure.
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [3:0] cmd_len;
  logic       mem_write_enable;
  logic       mem_read_enable;
  logic [7:0] mem_write_data;
  logic [7:0] mem_address;
  logic [7:0] mem_read_data;
  logic       mem_full;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] rsp_addr;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len,
    input  mem_read_data, mem_full,
    output cmd_ready, mem_write_enable, mem_read_enable, mem_write_data,
    output mem_address, rsp_valid, rsp_data, rsp_addr, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len,
    output mem_read_data, mem_full,
    input  cmd_ready, mem_write_enable, mem_read_enable, mem_write_data,
    input  mem_address, rsp_valid, rsp_data, rsp_addr, busy
  );
endinterface

// File: rtl/mem_requester.sv
// Burst initiator for the memory controller: turns write-fill / read commands into
// one registered strobe per cycle and returns read bytes as tagged response pulses.
module mem_requester #(
  parameter int READ_LATENCY = 1,
  parameter bit INCR_DATA    = 1'b1
) (
  input  logic            clk_master,
  input  logic            reset,
  mem_requester_if.master bus,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        base_q, base_d;
  logic [7:0]        seed_q, seed_d;
  logic [3:0]        len_q, len_d;
  logic [4:0]        k_q, k_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        addr_q, addr_d;
  logic              rv_q, rv_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [7:0]        raddr_q, raddr_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [READ_LATENCY-1:0] pv_q, pv_d;
  logic [7:0]        pa_q [READ_LATENCY];
  logic [7:0]        pa_d [READ_LATENCY];

  logic [7:0] beat_addr;
  logic [7:0] beat_data;
  logic       beats_done;
  logic       pipe_busy;

  // k_q counts beats already issued; once it passes len_q the burst is complete.
  assign beat_addr  = base_q + {3'b000, k_q};
  assign beat_data  = INCR_DATA ? (seed_q + {3'b000, k_q}) : seed_q;
  assign beats_done = (k_q > {1'b0, len_q});
  assign pipe_busy  = (|pv_q) | re_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    seed_d  = seed_q;
    len_d   = len_q;
    k_d     = k_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    wdata_d = wdata_q;
    addr_d  = addr_q;

    // Tag pipeline: stage i holds the address of the strobe issued i+1 cycles ago.
    pv_d[0] = re_q;
    pa_d[0] = addr_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
    rv_d    = pv_q[READ_LATENCY-1];
    rdata_d = pv_q[READ_LATENCY-1] ? bus.mem_read_data : rdata_q;
    raddr_d = pv_q[READ_LATENCY-1] ? pa_q[READ_LATENCY-1] : raddr_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          base_d = bus.cmd_addr;
          seed_d = bus.cmd_wdata;
          len_d  = bus.cmd_len;
          if (bus.cmd_write) begin
            state_d = WRITE;
            if (!bus.mem_full) begin
              we_d    = 1'b1;
              addr_d  = bus.cmd_addr;
              wdata_d = bus.cmd_wdata;
              k_d     = 5'd1;
            end else begin
              k_d = 5'd0;
            end
          end else begin
            state_d = READ;
            re_d    = 1'b1;
            addr_d  = bus.cmd_addr;
            k_d     = 5'd1;
          end
        end
      end
      WRITE: begin
        if (beats_done) begin
          state_d = IDLE;
        end else if (!bus.mem_full) begin
          we_d    = 1'b1;
          addr_d  = beat_addr;
          wdata_d = beat_data;
          k_d     = k_q + 5'd1;
        end
      end
      READ: begin
        if (beats_done) begin
          state_d = DRAIN;
        end else begin
          re_d   = 1'b1;
          addr_d = beat_addr;
          k_d    = k_q + 5'd1;
        end
      end
      DRAIN: begin
        if (!pipe_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_master or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= 8'h00;
      seed_q  <= 8'h00;
      len_q   <= 4'h0;
      k_q     <= 5'd0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      wdata_q <= 8'h00;
      addr_q  <= 8'h00;
      rv_q    <= 1'b0;
      rdata_q <= 8'h00;
      raddr_q <= 8'h00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      pv_q    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pa_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      k_q     <= k_d;
      we_q    <= we_d;
      re_q    <= re_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      raddr_q <= raddr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      pv_q    <= pv_d;
      for (int i = 0; i < READ_LATENCY; i++) pa_q[i] <= pa_d[i];
    end
  end

  assign bus.cmd_ready        = ready_q;
  assign bus.busy             = busy_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_read_enable  = re_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.mem_address      = addr_q;
  assign bus.rsp_valid        = rv_q;
  assign bus.rsp_data         = rdata_q;
  assign bus.rsp_addr         = raddr_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: write bursts with stalls, read bursts with
// address wrap, mid-burst reset and back-to-back command acceptance.
module tb_mem_requester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mem_requester_if bus();

  mem_requester #(.READ_LATENCY(1), .INCR_DATA(1'b1)) dut (
    .clk_master (clk),
    .reset      (rst_n),
    .bus        (bus),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];   // expected write beats {addr, data}
  logic [15:0] rsp_q[$];   // expected responses {addr, data}

  function automatic logic [7:0] mem_model(input logic [7:0] a);
    return a ^ 8'h7A;
  endfunction

  // Memory controller model with one cycle of read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.mem_read_data <= 8'h00;
    else if (bus.mem_read_enable) bus.mem_read_data <= mem_model(bus.mem_address);
  end

  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [3:0] len, input bit hold, output int waited);
    logic [7:0] ba, bd;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_len   = len;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 100) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, waited);
    end
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ba = a + 8'(i);
      bd = d + 8'(i);
      if (wr) exp_q.push_back({ba, bd});
      else    rsp_q.push_back({ba, mem_model(ba)});
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h00;
    bus.cmd_wdata = 8'h00; bus.cmd_len = 4'h0; bus.mem_full = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b busy=%b, required 1 0", bus.cmd_ready, bus.busy);
    end
    checks++;
    if ({bus.mem_write_enable, bus.mem_read_enable} !== 2'b00) begin
      errors++;
      $display("FAIL reset_strobes: we=%b re=%b, required 0 0", bus.mem_write_enable, bus.mem_read_enable);
    end
    checks++;
    if ({bus.mem_address, bus.mem_write_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h, required 00 00", bus.mem_address, bus.mem_write_data);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_addr} !== 17'h0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b data=%h addr=%h, required 0 00 00", bus.rsp_valid, bus.rsp_data, bus.rsp_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_incr();
    int w;
    logic [15:0] e;
    send_cmd(1'b1, 8'h10, 8'hA0, 4'd3, 1'b0, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_write_enable !== 1'b1) begin
        errors++;
        $display("FAIL write_strobe[%0d]: we=%b, required 1", i, bus.mem_write_enable);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.mem_address, bus.mem_write_data} !== e) begin
          errors++;
          $display("FAIL write_beat[%0d]: addr/data=%h, required %h", i, {bus.mem_address, bus.mem_write_data}, e);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_write_enable !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_done: busy=%b we=%b ready=%b, required 0 0 1", bus.busy, bus.mem_write_enable, bus.cmd_ready);
    end
    exp_q.delete();
  endtask

  task automatic test_write_stall();
    int w, strobes;
    logic [15:0] e, held;
    logic exp_we;
    strobes = 0;
    held = 16'h0;
    send_cmd(1'b1, 8'h10, 8'hA0, 4'd3, 1'b0, w);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_we = !(i == 1 || i == 2);
      checks++;
      if (bus.mem_write_enable !== exp_we) begin
        errors++;
        $display("FAIL stall_strobe[%0d]: we=%b, required %b", i, bus.mem_write_enable, exp_we);
      end
      if (bus.mem_write_enable === 1'b1) begin
        strobes++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          held = e;
          checks++;
          if ({bus.mem_address, bus.mem_write_data} !== e) begin
            errors++;
            $display("FAIL stall_beat[%0d]: addr/data=%h, required %h", i, {bus.mem_address, bus.mem_write_data}, e);
          end
        end
      end else begin
        checks++;
        if ({bus.mem_address, bus.mem_write_data} !== held) begin
          errors++;
          $display("FAIL stall_hold[%0d]: addr/data=%h, required %h", i, {bus.mem_address, bus.mem_write_data}, held);
        end
      end
      if (i == 0) bus.mem_full = 1'b1;
      if (i == 2) bus.mem_full = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: busy=%b we=%b, required 0 0", bus.busy, bus.mem_write_enable);
    end
    checks++;
    if (strobes != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count: strobes=%0d left=%0d, required 4 0", strobes, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_read_single();
    int w, n;
    logic [15:0] e;
    send_cmd(1'b0, 8'h20, 8'h00, 4'd0, 1'b0, w);
    @(negedge clk);
    checks++;
    if (bus.mem_read_enable !== 1'b1 || bus.mem_address !== 8'h20) begin
      errors++;
      $display("FAIL rd1_strobe: re=%b addr=%h, required 1 20", bus.mem_read_enable, bus.mem_address);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_read_enable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd1_gap: re=%b rsp_valid=%b, required 0 0", bus.mem_read_enable, bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd1_valid: rsp_valid=%b, required 1", bus.rsp_valid);
    end else if (rsp_q.size() > 0) begin
      e = rsp_q.pop_front();
      checks++;
      if ({bus.rsp_addr, bus.rsp_data} !== e || e[7:0] !== 8'h5A) begin
        errors++;
        $display("FAIL rd1_data: addr/data=%h, required %h", {bus.rsp_addr, bus.rsp_data}, e);
      end
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd1_idle: busy=%b ready=%b, required 0 1", bus.busy, bus.cmd_ready);
    end
    rsp_q.delete();
  endtask

  task automatic test_read_wrap();
    int w, nre, nrsp, first, last;
    logic [15:0] e;
    logic [7:0] ea;
    nre = 0; nrsp = 0; first = -1; last = -1;
    send_cmd(1'b0, 8'hFE, 8'h00, 4'd3, 1'b0, w);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_read_enable === 1'b1 && bus.mem_write_enable === 1'b1) begin
        errors++;
        $display("FAIL wrap_excl[%0d]: we=1 re=1, required at most one", c);
      end
      if (bus.mem_read_enable === 1'b1) begin
        ea = 8'hFE + 8'(nre);
        checks++;
        if (bus.mem_address !== ea) begin
          errors++;
          $display("FAIL wrap_addr[%0d]: addr=%h, required %h", nre, bus.mem_address, ea);
        end
        nre++;
      end
      if (bus.rsp_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        nrsp++;
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra: rsp addr/data=%h, required no response", {bus.rsp_addr, bus.rsp_data});
        end else begin
          e = rsp_q.pop_front();
          if ({bus.rsp_addr, bus.rsp_data} !== e) begin
            errors++;
            $display("FAIL wrap_rsp[%0d]: addr/data=%h, required %h", nrsp - 1, {bus.rsp_addr, bus.rsp_data}, e);
          end
        end
      end
      if (nrsp == 4 && bus.busy === 1'b0) break;
    end
    checks++;
    if (nre != 4 || nrsp != 4 || (last - first) != 3) begin
      errors++;
      $display("FAIL wrap_count: strobes=%0d rsps=%0d span=%0d, required 4 4 3", nre, nrsp, last - first);
    end
    rsp_q.delete();
  endtask

  task automatic test_reset_mid();
    int w, stray;
    stray = 0;
    send_cmd(1'b0, 8'h40, 8'h00, 4'd15, 1'b0, w);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mem_read_enable !== 1'b1 || bus.mem_address !== 8'h42) begin
      errors++;
      $display("FAIL rst_mid_beat2: re=%b addr=%h, required 1 42", bus.mem_read_enable, bus.mem_address);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_read_enable !== 1'b0 || bus.mem_address !== 8'h00 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outs: re=%b addr=%h rsp_valid=%b, required 0 00 0", bus.mem_read_enable, bus.mem_address, bus.rsp_valid);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready: ready=%b busy=%b, required 1 0", bus.cmd_ready, bus.busy);
    end
    rsp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h60;
    bus.cmd_wdata = 8'h05; bus.cmd_len = 4'd0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_write_enable !== 1'b1 || {bus.mem_address, bus.mem_write_data} !== 16'h6005) begin
      errors++;
      $display("FAIL rst_mid_fresh: we=%b addr/data=%h, required 1 6005", bus.mem_write_enable, {bus.mem_address, bus.mem_write_data});
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) stray++;
    end
    checks++;
    if (stray != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_flush: stray_rsps=%0d busy=%b, required 0 0", stray, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int w, n;
    logic [15:0] e;
    send_cmd(1'b1, 8'h30, 8'h80, 4'd1, 1'b1, w);
    bus.cmd_write = 1'b1; bus.cmd_addr = 8'h50; bus.cmd_wdata = 8'h11; bus.cmd_len = 4'd0;
    exp_q.push_back(16'h5011);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_write_enable !== 1'b1 || bus.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first[%0d]: we=%b ready=%b, required 1 0", c, bus.mem_write_enable, bus.cmd_ready);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.mem_address, bus.mem_write_data} !== e) begin
          errors++;
          $display("FAIL b2b_beat[%0d]: addr/data=%h, required %h", c, {bus.mem_address, bus.mem_write_data}, e);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.mem_write_enable !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: we=%b ready=%b, required 0 1", bus.mem_write_enable, bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.mem_write_enable !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL b2b_second: we=%b, required 1", bus.mem_write_enable);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.mem_address, bus.mem_write_data} !== e) begin
        errors++;
        $display("FAIL b2b_second_beat: addr/data=%h, required %h", {bus.mem_address, bus.mem_write_data}, e);
      end
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: busy=%b, required 0", bus.busy);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_write_incr();
    test_write_stall();
    test_read_single();
    test_read_wrap();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
